// File: rtl/minisrc_defs.sv
// rtl/minisrc_defs.sv - shared opcode, ALU and state definitions for the Mini SRC control unit
//
// Purpose: constants and types shared by control_sequencer and instr_class.
// Ports: none (package).

package minisrc_defs;

  // Width of the opcode field IR[31:27] and of op_sel.
  localparam int OPW = 5;

  // Instruction opcodes.
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on op_sel (they equal the ALU opcodes).
  localparam logic [OPW-1:0] ALU_NONE = 5'b00000;
  localparam logic [OPW-1:0] ALU_ADD  = 5'b00011;
  localparam logic [OPW-1:0] ALU_SUB  = 5'b00100;
  localparam logic [OPW-1:0] ALU_AND  = 5'b00101;
  localparam logic [OPW-1:0] ALU_OR   = 5'b00110;

  // Sequencer states: fetch T0-T2, execute T3-T7.
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_IDLE = 4'd1,
    ST_T0   = 4'd2,
    ST_T1   = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8,
    ST_T7   = 4'd9,
    ST_HALT = 4'd10
  } state_t;

endpackage

// File: rtl/instr_class.sv
// rtl/instr_class.sv - combinational opcode classifier
//
// Purpose: maps a 5-bit opcode onto instruction-class flags and the ALU
// operation that the execute steps use.
// Ports:
//   opcode     in  5  opcode field
//   is_mem_ld  out 1  ld/ldi/st: shares the base+offset address step
//   is_ld      out 1  ld
//   is_ldi     out 1  ldi
//   is_st      out 1  st
//   is_alu3    out 1  add/sub/and/or (register-register)
//   is_imm     out 1  addi/andi/ori
//   is_nop     out 1  nop or any unlisted opcode
//   is_halt    out 1  halt
//   alu_op     out 5  ALU operation for the T4 step

module instr_class
  import minisrc_defs::*;
(
  input  logic [OPW-1:0] opcode,
  output logic           is_mem_ld,
  output logic           is_ld,
  output logic           is_ldi,
  output logic           is_st,
  output logic           is_alu3,
  output logic           is_imm,
  output logic           is_nop,
  output logic           is_halt,
  output logic [OPW-1:0] alu_op
);

  always_comb begin
    is_ld   = 1'b0;
    is_ldi  = 1'b0;
    is_st   = 1'b0;
    is_alu3 = 1'b0;
    is_imm  = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    alu_op  = ALU_NONE;
    case (opcode)
      OP_LD:   begin is_ld  = 1'b1; alu_op = ALU_ADD; end
      OP_LDI:  begin is_ldi = 1'b1; alu_op = ALU_ADD; end
      OP_ST:   begin is_st  = 1'b1; alu_op = ALU_ADD; end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        is_alu3 = 1'b1;
        alu_op  = opcode;
      end
      OP_ADDI: begin is_imm = 1'b1; alu_op = ALU_ADD; end
      OP_ANDI: begin is_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin is_imm = 1'b1; alu_op = ALU_OR;  end
      OP_HALT: is_halt = 1'b1;
      // nop and every unlisted opcode behave identically
      default: is_nop = 1'b1;
    endcase
    is_mem_ld = is_ld | is_ldi | is_st;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Mini SRC control unit (fetch T0-T2, execute T3-T7)
//
// Purpose: one FSM stepping the Mini SRC datapath through fetch and execute,
// driving every datapath control line as a Moore decode of the state register
// plus the latched opcode.
// Ports:
//   clk            in  1   system clock, rising edge
//   clr            in  1   synchronous active-high reset
//   ir             in  32  current IR contents
//   stop           in  1   park in IDLE at the next instruction boundary
//   R_out..In_out  out 1   bus drivers
//   Rin..PC_rd     out 1   bus loaders
//   Gra/Grb/Grc    out 1   register-field select
//   Read/Write     out 1   memory strobes
//   IncPC          out 1   PC increment
//   op_sel         out 5   ALU operation
//   run            out 1   high in T0-T7

module control_sequencer
  import minisrc_defs::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    ir,
  input  logic           stop,
  output logic           R_out,
  output logic           BAout,
  output logic           C_out,
  output logic           MDR_out,
  output logic           Zlo_out,
  output logic           PC_out,
  output logic           HI_out,
  output logic           LO_out,
  output logic           Zhi_out,
  output logic           MAR_out,
  output logic           In_out,
  output logic           Rin,
  output logic           MAR_rd,
  output logic           MDR_rd,
  output logic           IR_rd,
  output logic           Y_rd,
  output logic           Zlo_rd,
  output logic           PC_rd,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Read,
  output logic           Write,
  output logic           IncPC,
  output logic [OPW-1:0] op_sel,
  output logic           run
);

  state_t         state_q, state_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic [OPW-1:0] cur_opc;
  logic           is_mem_ld, is_ld, is_ldi, is_st, is_alu3, is_imm, is_nop, is_halt;
  logic [OPW-1:0] alu_op;
  state_t         boundary_state;

  // Only the opcode field of IR steers the sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[31-OPW:0];

  // T3 has to act on the freshly loaded IR; later steps use the latched copy
  // so the datapath may change IR without disturbing the instruction.
  assign cur_opc = (state_q == ST_T3) ? ir[31 -: OPW] : opc_q;

  instr_class u_instr_class (
    .opcode    (cur_opc),
    .is_mem_ld (is_mem_ld),
    .is_ld     (is_ld),
    .is_ldi    (is_ldi),
    .is_st     (is_st),
    .is_alu3   (is_alu3),
    .is_imm    (is_imm),
    .is_nop    (is_nop),
    .is_halt   (is_halt),
    .alu_op    (alu_op)
  );

  // Where to go after the last step of an instruction.
  assign boundary_state = stop ? ST_IDLE : ST_T0;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    case (state_q)
      ST_RST:  state_d = boundary_state;
      ST_IDLE: if (!stop) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        opc_d = ir[31 -: OPW];
        if (is_halt)     state_d = ST_HALT;
        else if (is_nop) state_d = boundary_state;
        else             state_d = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (is_ld | is_st) ? ST_T6 : boundary_state;
      ST_T6:   state_d = ST_T7;
      ST_T7:   state_d = boundary_state;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RST;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // These bus drivers are never needed by the supported instruction set.
  assign HI_out  = 1'b0;
  assign LO_out  = 1'b0;
  assign Zhi_out = 1'b0;
  assign MAR_out = 1'b0;
  assign In_out  = 1'b0;

  assign run = (state_q >= ST_T0) && (state_q <= ST_T7);

  always_comb begin
    R_out   = 1'b0;
    BAout   = 1'b0;
    C_out   = 1'b0;
    MDR_out = 1'b0;
    Zlo_out = 1'b0;
    PC_out  = 1'b0;
    Rin     = 1'b0;
    MAR_rd  = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    PC_rd   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    IncPC   = 1'b0;
    op_sel  = ALU_NONE;
    case (state_q)
      ST_T0: begin PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1; end
      ST_T1: begin Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1; end
      ST_T2: begin MDR_out = 1'b1; IR_rd = 1'b1; end
      ST_T3: begin
        if (is_mem_ld) begin
          Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1;
        end else if (is_alu3 | is_imm) begin
          Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1;
        end
      end
      ST_T4: begin
        if (is_mem_ld | is_imm) begin
          C_out = 1'b1; Zlo_rd = 1'b1; op_sel = alu_op;
        end else if (is_alu3) begin
          Grc = 1'b1; R_out = 1'b1; Zlo_rd = 1'b1; op_sel = alu_op;
        end
      end
      ST_T5: begin
        if (is_ld | is_st) begin
          Zlo_out = 1'b1; MAR_rd = 1'b1;
        end else if (is_ldi | is_alu3 | is_imm) begin
          Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      ST_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDR_rd = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1;
        end
      end
      ST_T7: begin
        if (is_ld) begin
          MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        stop = 1'b0;
  logic R_out, BAout, C_out, MDR_out, Zlo_out, PC_out, HI_out, LO_out, Zhi_out, MAR_out, In_out;
  logic Rin, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, PC_rd, Gra, Grb, Grc, Read, Write, IncPC;
  logic [4:0] op_sel;
  logic run;

  int n_cmp = 0;
  int n_fail = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .R_out(R_out), .BAout(BAout), .C_out(C_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out),
    .MAR_out(MAR_out), .In_out(In_out),
    .Rin(Rin), .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
    .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .op_sel(op_sel), .run(run)
  );

  always #5 clk = ~clk;

  // Observed control word: 24 single-bit lines above the 5-bit op_sel.
  localparam int I_R_OUT = 28, I_BAOUT = 27, I_C_OUT = 26, I_MDR_OUT = 25, I_ZLO_OUT = 24;
  localparam int I_PC_OUT = 23, I_RIN = 17, I_MAR_RD = 16, I_MDR_RD = 15, I_IR_RD = 14;
  localparam int I_Y_RD = 13, I_ZLO_RD = 12, I_PC_RD = 11, I_GRA = 10, I_GRB = 9, I_GRC = 8;
  localparam int I_READ = 7, I_WRITE = 6, I_INCPC = 5;

  logic [28:0] obs;
  assign obs = {R_out, BAout, C_out, MDR_out, Zlo_out, PC_out, HI_out, LO_out, Zhi_out,
                MAR_out, In_out, Rin, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, PC_rd,
                Gra, Grb, Grc, Read, Write, IncPC, op_sel};

  // Reference: the control word the spec lists for opcode `op` at step Ts.
  function automatic logic [28:0] exp_ctl(input logic [4:0] op, input int s);
    logic [28:0] e;
    int o;
    bit mem, alu3, imm;
    e = '0;
    o = int'(op);
    mem  = (o <= 2);
    alu3 = (o >= 3 && o <= 6);
    imm  = (o >= 12 && o <= 14);
    case (s)
      0: begin e[I_PC_OUT] = 1; e[I_MAR_RD] = 1; e[I_INCPC] = 1; e[I_ZLO_RD] = 1; end
      1: begin e[I_ZLO_OUT] = 1; e[I_PC_RD] = 1; e[I_READ] = 1; e[I_MDR_RD] = 1; end
      2: begin e[I_MDR_OUT] = 1; e[I_IR_RD] = 1; end
      3: begin
        if (mem) begin e[I_GRB] = 1; e[I_BAOUT] = 1; e[I_Y_RD] = 1; end
        if (alu3 || imm) begin e[I_GRB] = 1; e[I_R_OUT] = 1; e[I_Y_RD] = 1; end
      end
      4: begin
        e[I_ZLO_RD] = 1;
        if (alu3) begin e[I_GRC] = 1; e[I_R_OUT] = 1; e[4:0] = op; end
        else begin
          e[I_C_OUT] = 1;
          e[4:0] = (o == 13) ? 5'd5 : (o == 14) ? 5'd6 : 5'd3;
        end
      end
      5: begin
        e[I_ZLO_OUT] = 1;
        if (o == 0 || o == 2) e[I_MAR_RD] = 1;
        else begin e[I_GRA] = 1; e[I_RIN] = 1; end
      end
      6: begin
        if (o == 0) begin e[I_READ] = 1; e[I_MDR_RD] = 1; end
        else begin e[I_GRA] = 1; e[I_R_OUT] = 1; e[I_MDR_RD] = 1; end
      end
      7: begin
        if (o == 0) begin e[I_MDR_OUT] = 1; e[I_GRA] = 1; e[I_RIN] = 1; end
        else e[I_WRITE] = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Number of T-steps (cycles) an instruction occupies.
  function automatic int ins_len(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o == 0 || o == 2) return 8;
    if ((o >= 1 && o <= 6) || (o >= 12 && o <= 14)) return 6;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'(obs), 32'd0);
    chk({tag, "_run"}, 32'(run), 32'd0);
  endtask

  // Sample one cycle: IR holds the instruction only during T3, junk elsewhere.
  task automatic step_check(input logic [31:0] instr, input int s);
    @(posedge clk); #1;
    ir = (s == 3) ? instr : $urandom;
    #1;
    chk($sformatf("op%02h_T%0d_ctl", instr[31:27], s), 32'(obs), 32'(exp_ctl(instr[31:27], s)));
    chk($sformatf("op%02h_T%0d_run", instr[31:27], s), 32'(run), 32'd1);
  endtask

  // Park in IDLE for a few cycles, then release stop (T0 follows next edge).
  task automatic idle_phase();
    int k;
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #2;
      chk_quiet("idle");
    end
    stop = 1'b0;
  endtask

  // stop_mode: -1 none, -2 random level each step, else raise stop after step stop_mode.
  task automatic run_instr(input logic [31:0] instr, input int stop_mode);
    int n;
    n = ins_len(instr[31:27]);
    for (int s = 0; s < n; s++) begin
      step_check(instr, s);
      if (stop_mode == -2) stop = ($urandom_range(0, 5) == 0);
      else if (s == stop_mode) stop = 1'b1;
    end
    if (stop) idle_phase();
  endtask

  // Run steps T0..T<cut>, pulse clr, confirm the RST cycle is silent.
  task automatic run_cut(input logic [31:0] instr, input int cut);
    for (int s = 0; s <= cut; s++) step_check(instr, s);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk_quiet($sformatf("clr_after_T%0d", cut));
    chk("clr_write", 32'(Write), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    logic [4:0] pick [14];
    pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd26, 5'd0, 5'd0, 5'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset");
    clr = 1'b0;

    // Directed program: ld, st, add, addi
    run_instr(32'h0080_0054, -1);
    run_instr(32'h1180_0034, -1);
    run_instr(32'h1A92_0000, -1);
    run_instr(32'h6117_FFFB, -1);

    // stop during ldi T4: completes T5, idles, resumes at T0
    run_instr(32'h0880_0007, 4);
    run_instr(32'h3000_0000, -1);

    // clr during st T6 and T7, and during ld at a random step
    run_cut(32'h1180_0034, 6);
    run_cut(32'h1180_0034, 7);
    run_cut(32'h0080_0054, $urandom_range(0, 7));

    // clr and stop together: clr wins, then stop parks in IDLE
    stop = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk_quiet("clr_stop");
    idle_phase();

    // Randomized instruction stream with random stop levels
    for (int i = 0; i < 60; i++) begin
      op = pick[$urandom_range(0, 13)];
      if (op == 5'd0 && $urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, -2);
    end

    // halt: HALT after T3, silent for 20 cycles regardless of stop
    stop = 1'b0;
    run_instr(32'hD800_0000, -1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      stop = $urandom_range(0, 1) == 1;
      ir = $urandom;
      #1;
      chk_quiet("halt");
    end
    stop = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk_quiet("halt_clr");
    run_instr(32'h1A92_0000, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Mini SRC datapath: one FSM that steps through fetch T0–T2 and execute T3–T7 and drives every datapath control line each clock. It replaces the hand-sequenced stimulus now used in the datapath benches. Its inputs are the IR contents and run/stop control. Its outputs connect one-to-one to the `Datapath` control ports.

## Interface
- `OPW`, 5, opcode field width (IR[31:27]).
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  reset, synchronous, active-high; shares the net with `Datapath.clr`.
- `ir`  in  32  current IR contents (`IR_view`).
- `stop`  in  1  level; when high, the sequencer parks at the next instruction boundary.
- Bus drivers, each `out 1`: `R_out`, `BAout`, `C_out`, `MDR_out`, `Zlo_out`, `PC_out`, `HI_out`, `LO_out`, `Zhi_out`, `MAR_out`, `In_out`.
- Bus loaders, each `out 1`: `Rin`, `MAR_rd`, `MDR_rd`, `IR_rd`, `Y_rd`, `Zlo_rd`, `PC_rd`.
- Register select, each `out 1`: `Gra`, `Grb`, `Grc`.
- Memory and PC, each `out 1`: `Read`, `Write`, `IncPC`.
- `op_sel`  out  5  ALU operation; equals the ALU opcode. ADD=00011, SUB=00100, AND=00101, OR=00110.
- `run`  out  1  high while executing; low in RST, IDLE and HALT.

## Operation
- States: RST, IDLE, T0–T7, HALT.
- Outputs are a Moore decode of the state register plus the latched opcode. Every output not listed for a state is 0. `op_sel` defaults to 0.
- Fetch, common to all instructions:
  - T0: `PC_out`, `MAR_rd`, `IncPC`, `Zlo_rd`.
  - T1: `Zlo_out`, `PC_rd`, `Read`, `MDR_rd`.
  - T2: `MDR_out`, `IR_rd`.
- Opcode `ir[31:27]` is sampled at the end of T3 and held in `opc` until the next T3. T3 decodes directly from `ir`.
- ld (00000):
  - T3: `Grb`, `BAout`, `Y_rd`.
  - T4: `C_out`, `op_sel`=ADD, `Zlo_rd`.
  - T5: `Zlo_out`, `MAR_rd`.
  - T6: `Read`, `MDR_rd`.
  - T7: `MDR_out`, `Gra`, `Rin`.
- ldi (00001): T3 and T4 as ld; T5: `Zlo_out`, `Gra`, `Rin`.
- st (00010):
  - T3–T5 as ld.
  - T6: `Gra`, `R_out`, `MDR_rd`.
  - T7: `Write`.
- add, sub, and, or (00011–00110):
  - T3: `Grb`, `R_out`, `Y_rd`.
  - T4: `Grc`, `R_out`, `op_sel`=opcode, `Zlo_rd`.
  - T5: `Zlo_out`, `Gra`, `Rin`.
- addi (01100), andi (01101), ori (01110):
  - T3: `Grb`, `R_out`, `Y_rd`.
  - T4: `C_out`, `Zlo_rd`, `op_sel` = ADD, AND or OR respectively.
  - T5: `Zlo_out`, `Gra`, `Rin`.
- nop (11010) and every unlisted opcode: T3 asserts nothing; next state is T0.
- halt (11011): T3 goes to HALT. HALT holds all outputs 0 until `clr`.
- Transitions:
  - RST→T0, or RST→IDLE if `stop`.
  - IDLE→T0 when `stop`=0.
  - Last execute step → T0, or → IDLE if `stop`=1 in that cycle.
  - Last step is T5 for ldi/ALU/imm, T7 for ld/st, T3 for nop.
  - `stop` never interrupts a step mid-instruction.

## Timing
- Each T-step is exactly one clock. Memory is assumed ready within one cycle; there are no wait states.
- Instruction lengths:
  - ld/st: 8 cycles T0–T7.
  - ldi/ALU/imm: 6 cycles.
  - nop: 4 cycles.
- `clr`=1 at an edge puts the FSM in RST next cycle, from any state, and all outputs go 0 that cycle.
  - A reset during st T7 ends `Write` after that cycle.
  - A partially executed instruction is abandoned and is not resumed.
- Reset values: state=RST, `opc`=0, every output 0, `run`=0.
- If `clr` and `stop` are both high, `clr` wins. `stop` is ignored in HALT.

## Structure
- Shared package `minisrc_defs`: opcode constants (OP_LD … OP_HALT), ALU `op_sel` constants, state encoding.
- One sub-module `instr_class`: combinational opcode → {is_mem_ld, is_ld, is_ldi, is_st, is_alu3, is_imm, is_nop, is_halt, alu_op}.
- The FSM and output decode live in `control_sequencer`.

## Test plan
Each scenario runs against `Datapath` plus RAM.
- Release `clr` with `stop`=0; PC=5; RAM[5]=0x00800054 (ld r1,0x54(r0)); RAM[0x54]=0x1234.
  - T0 at cycle 1; r1=0x1234 after T7; PC=6; next T0 starts at cycle 9.
- R3=0xB6; IR=0x11800034 (st 0x34,R3); RAM[0x34]=0x25.
  - `Write` high in T7 only; RAM[0x34]=0xB6 afterward.
- r2=7, r4=3; 0x1A920000 (add r5,r2,r4), then 0x6117FFFB (addi r2,r2,-5).
  - `op_sel`=00011 in T4 of each; r5=10; r2=2; each instruction 6 cycles.
- 0xD8000000 (halt).
  - HALT after T3; `run`=0; outputs stay 0 for 20 cycles; `clr` restarts at T0.
- `clr` asserted in T6 of a st.
  - RST next cycle; `Write` never asserts; RAM unchanged.
- `stop`=1 during ldi T4.
  - Instruction completes T5 and enters IDLE; `run`=0; `stop`=0 resumes T0 next cycle.
